// File: rtl/alu_pkg.sv
// Shared definitions for the lab ALU datapath blocks.
// Holds the divider FSM state type and its counter sizing.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_N_DEFAULT = 4;
    localparam int DIV_CNT_W     = $clog2(DIV_N_DEFAULT + 1);

    // Counter must hold the value N itself, hence N+1 codes.
    function automatic int div_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract,
// keep the difference only when it did not borrow.
module div_step #(
    parameter int N = 4
) (
    input  logic [N:0]   rem_in,
    input  logic         dvd_msb,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N+1:0] trial;

    // One guard bit above the shifted remainder makes the borrow explicit.
    assign trial   = {rem_in, dvd_msb} - {2'b00, divisor};
    assign q_bit   = ~trial[N+1];
    assign rem_out = q_bit ? trial[N:0] : {rem_in[N-1:0], dvd_msb};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider, signed or unsigned, with start/busy/done
// handshake and divide-by-zero / signed-overflow flags.
module seq_divider
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N-1:0] dividendo,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] cociente,
    output logic [N-1:0] residuo,
    output logic         busy,
    output logic         done,
    output logic         div_cero,
    output logic         overflow
);

    localparam int CW = div_cnt_width(N);
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

    div_state_t   state_reg;
    logic [CW-1:0] cnt_reg;
    logic [N-1:0] dvd_reg;
    logic [N-1:0] dsr_reg;
    logic [N:0]   rem_reg;
    logic         smode_reg;
    logic         sign_q_reg;
    logic         sign_r_reg;
    logic         pend_dz_reg;
    logic         pend_ov_reg;
    logic [N-1:0] cociente_reg;
    logic [N-1:0] residuo_reg;
    logic         busy_reg;
    logic         done_reg;
    logic         div_cero_reg;
    logic         overflow_reg;

    logic         a_neg, b_neg;
    logic [N-1:0] abs_a, abs_b;
    logic [N-1:0] q_fix, r_fix;
    logic [N:0]   step_rem;
    logic         step_q;

    always_comb begin
        a_neg = signed_mode & dividendo[N-1];
        b_neg = signed_mode & divisor[N-1];
        abs_a = a_neg ? (~dividendo + 1'b1) : dividendo;
        abs_b = b_neg ? (~divisor + 1'b1) : divisor;
        q_fix = (smode_reg & sign_q_reg) ? (~dvd_reg + 1'b1) : dvd_reg;
        r_fix = (smode_reg & sign_r_reg) ? (~rem_reg[N-1:0] + 1'b1) : rem_reg[N-1:0];
    end

    div_step #(.N(N)) u_step (
        .rem_in  (rem_reg),
        .dvd_msb (dvd_reg[N-1]),
        .divisor (dsr_reg),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            dvd_reg      <= '0;
            dsr_reg      <= '0;
            rem_reg      <= '0;
            smode_reg    <= 1'b0;
            sign_q_reg   <= 1'b0;
            sign_r_reg   <= 1'b0;
            pend_dz_reg  <= 1'b0;
            pend_ov_reg  <= 1'b0;
            cociente_reg <= '0;
            residuo_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_cero_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        busy_reg     <= 1'b1;
                        div_cero_reg <= 1'b0;
                        overflow_reg <= 1'b0;
                        smode_reg    <= signed_mode;
                        pend_dz_reg  <= 1'b0;
                        pend_ov_reg  <= 1'b0;
                        if (divisor == '0) begin
                            // Special results are staged here and published from DONE.
                            pend_dz_reg <= 1'b1;
                            dvd_reg     <= ALL_ONES;
                            rem_reg     <= {1'b0, dividendo};
                            state_reg   <= DONE;
                        end else if (signed_mode && dividendo == MOST_NEG && divisor == ALL_ONES) begin
                            pend_ov_reg <= 1'b1;
                            dvd_reg     <= dividendo;
                            rem_reg     <= '0;
                            state_reg   <= DONE;
                        end else begin
                            dvd_reg    <= abs_a;
                            dsr_reg    <= abs_b;
                            rem_reg    <= '0;
                            sign_q_reg <= a_neg ^ b_neg;
                            sign_r_reg <= a_neg;
                            cnt_reg    <= CW'(N);
                            state_reg  <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_reg <= step_rem;
                    dvd_reg <= {dvd_reg[N-2:0], step_q};
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    cociente_reg <= q_fix;
                    residuo_reg  <= r_fix;
                    done_reg     <= 1'b1;
                    busy_reg     <= 1'b0;
                    state_reg    <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                    if (pend_dz_reg || pend_ov_reg) begin
                        cociente_reg <= dvd_reg;
                        residuo_reg  <= rem_reg[N-1:0];
                        div_cero_reg <= pend_dz_reg;
                        overflow_reg <= pend_ov_reg;
                        pend_dz_reg  <= 1'b0;
                        pend_ov_reg  <= 1'b0;
                        done_reg     <= 1'b1;
                        busy_reg     <= 1'b0;
                    end else begin
                        done_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cociente = cociente_reg;
    assign residuo  = residuo_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign div_cero = div_cero_reg;
    assign overflow = overflow_reg;

endmodule
